// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and arithmetic helpers for the sequenced systolic array
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, STREAM, DRAIN} state_t;

    // Adds two sign-extended operands; clamps to an acc_w-bit signed range when saturate is set,
    // otherwise the caller's truncation to acc_w bits gives two's-complement wrap.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int acc_w,
                                                   input bit saturate);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (acc_w - 1));
        if (saturate) begin
            if (s > hi) begin
                s = hi;
            end else if (s < lo) begin
                s = lo;
            end
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/systolic_array_seq_pe.sv
// rtl/systolic_array_seq_pe.sv - one processing element: data, weight, bias and accumulator registers
module systolic_pe_p
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic                     weight_we,
    input  logic                     bias_we,
    input  logic                     acc_init,
    input  logic signed [DATA_W-1:0] din,
    input  logic signed [DATA_W-1:0] ld_data,
    output logic signed [DATA_W-1:0] dout,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W-1:0]   weight;
    logic signed [DATA_W-1:0]   bias;
    logic signed [DATA_W-1:0]   init_bias;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [63:0]         sum;

    // The last bias beat and the accumulator preset land in the same cycle, so forward the beat.
    assign init_bias = bias_we ? ld_data : bias;
    assign prod      = (2*DATA_W)'(din) * (2*DATA_W)'(weight);
    assign sum       = sat_add(64'(acc), 64'(prod), ACC_W, SATURATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight <= '0;
            bias   <= '0;
            dout   <= '0;
            acc    <= '0;
        end else begin
            if (weight_we) begin
                weight <= ld_data;
            end
            if (bias_we) begin
                bias <= ld_data;
            end
            if (acc_init) begin
                acc  <= ACC_W'(init_bias);
                dout <= '0;
            end else if (shift_en) begin
                dout <= din;
                acc  <= ACC_W'(sum);
            end
        end
    end

endmodule

// File: rtl/systolic_array_seq.sv
// rtl/systolic_array_seq.sv - linear systolic array with load/stream/drain sequencer
module systolic_array_seq
    import systolic_pkg::*;
#(
    parameter int N_PE     = 8,
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 8,
    parameter int LEN_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load_w,
    input  logic                     load_b,
    input  logic [LEN_W-1:0]         len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = $clog2(N_PE);
    localparam int CNT_W = (LEN_W > IDX_W) ? LEN_W : IDX_W;

    state_t             state;
    state_t             nxt;
    logic               lb_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   drain_idx;
    logic               accept;
    logic               last_load;
    logic               last_data;
    logic               acc_init;

    logic signed [DATA_W-1:0] data_arr [N_PE];
    logic signed [ACC_W-1:0]  acc_arr  [N_PE];

    assign in_ready  = (state == LOAD_W) || (state == LOAD_B) || (state == STREAM);
    assign accept    = in_valid && in_ready;
    assign last_load = accept && (beat_cnt == CNT_W'(N_PE - 1));
    assign last_data = accept && (beat_cnt == CNT_W'(len_q) - CNT_W'(1));
    assign busy      = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (drain_idx == IDX_W'(N_PE - 1));
    assign out_data  = (state == DRAIN) ? acc_arr[drain_idx] : '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (load_w)          nxt = LOAD_W;
                    else if (load_b)     nxt = LOAD_B;
                    else if (len != '0)  nxt = STREAM;
                    else                 nxt = DRAIN;
                end
            end
            LOAD_W: begin
                if (last_load) begin
                    if (lb_q)             nxt = LOAD_B;
                    else if (len_q != '0) nxt = STREAM;
                    else                  nxt = DRAIN;
                end
            end
            LOAD_B: begin
                if (last_load) nxt = (len_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                if (last_data) nxt = DRAIN;
            end
            DRAIN: begin
                if (out_ready && out_last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Accumulators are preset to bias exactly once, on the edge that first enters STREAM or DRAIN.
    assign acc_init = ((nxt == STREAM) || (nxt == DRAIN)) && (state != STREAM) && (state != DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lb_q      <= 1'b0;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_idx <= '0;
            done      <= 1'b0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lb_q      <= load_b;
                        len_q     <= len;
                        beat_cnt  <= '0;
                        drain_idx <= '0;
                    end
                end
                LOAD_W, LOAD_B: begin
                    if (accept) beat_cnt <= last_load ? '0 : beat_cnt + CNT_W'(1);
                end
                STREAM: begin
                    if (accept) beat_cnt <= last_data ? '0 : beat_cnt + CNT_W'(1);
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            drain_idx <= '0;
                            done      <= 1'b1;
                        end else begin
                            drain_idx <= drain_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_PE; i++) begin : g_pe
        logic signed [DATA_W-1:0] pe_in;
        if (i == 0) begin : g_head
            assign pe_in = in_data;
        end else begin : g_tail
            assign pe_in = data_arr[i-1];
        end

        systolic_pe_p #(
            .DATA_W   (DATA_W),
            .ACC_W    (ACC_W),
            .SATURATE (SATURATE)
        ) u_pe (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en  ((state == STREAM) && accept),
            .weight_we ((state == LOAD_W) && accept && (beat_cnt == CNT_W'(i))),
            .bias_we   ((state == LOAD_B) && accept && (beat_cnt == CNT_W'(i))),
            .acc_init  (acc_init),
            .din       (pe_in),
            .ld_data   (in_data),
            .dout      (data_arr[i]),
            .acc       (acc_arr[i])
        );
    end

endmodule

// File: tb/tb_systolic_array_seq.sv
// tb/tb_systolic_array_seq.sv - self-checking bench for systolic_array_seq (wrap and saturate instances)
module tb_systolic_array_seq;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              load_w = 1'b0;
    logic              load_b = 1'b0;
    logic [7:0]        len = '0;
    logic              in_valid = 1'b0;
    logic signed [3:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              in_ready_w, out_valid_w, out_last_w, busy_w, done_w;
    logic signed [7:0] out_data_w;
    logic              in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
    logic signed [7:0] out_data_s;

    int checks = 0;
    int errors = 0;

    int mw [NP];
    int mb [NP];
    int exp_w [NP];
    int exp_s [NP];
    int wq[$];
    int bq[$];
    int xq[$];

    always #5 clk = ~clk;

    systolic_array_seq #(.N_PE(NP), .DATA_W(4), .ACC_W(8), .LEN_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w), .load_b(load_b), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_last(out_last_w), .busy(busy_w), .done(done_w)
    );

    systolic_array_seq #(.N_PE(NP), .DATA_W(4), .ACC_W(8), .LEN_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w), .load_b(load_b), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_last(out_last_s), .busy(busy_s), .done(done_s)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fit(input int v, input bit sat);
        int r;
        if (sat) begin
            r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
        end else begin
            r = v & 255;
            if (r >= 128) r = r - 256;
        end
        return r;
    endfunction

    // PE i sees stream element t-i at beat t; each beat adds x*w to that PE's running sum.
    task automatic model_run();
        for (int i = 0; i < NP; i++) begin
            int aw;
            int as_;
            aw  = mb[i];
            as_ = mb[i];
            for (int t = 0; t < xq.size(); t++) begin
                int x;
                x   = (t >= i) ? xq[t-i] : 0;
                aw  = fit(aw + x * mw[i], 1'b0);
                as_ = fit(as_ + x * mw[i], 1'b1);
            end
            exp_w[i] = aw;
            exp_s[i] = as_;
        end
    endtask

    task automatic send(input int d, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = 4'(d);
        @(negedge clk);
        chk("in_ready_w", in_ready_w, 1);
        chk("in_ready_s", in_ready_s, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_at);
        for (int k = 0; k < NP; k++) begin
            out_ready = (k != stall_at);
            @(negedge clk);
            chk($sformatf("out_valid_w%0d", k), out_valid_w, 1);
            chk($sformatf("out_valid_s%0d", k), out_valid_s, 1);
            chk($sformatf("out_data_w%0d", k), out_data_w, exp_w[k]);
            chk($sformatf("out_data_s%0d", k), out_data_s, exp_s[k]);
            chk($sformatf("out_last_w%0d", k), out_last_w, (k == NP - 1) ? 1 : 0);
            if (k == stall_at) begin
                repeat (5) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk($sformatf("stall_data_w%0d", k), out_data_w, exp_w[k]);
                    chk($sformatf("stall_data_s%0d", k), out_data_s, exp_s[k]);
                    chk($sformatf("stall_last_s%0d", k), out_last_s, (k == NP - 1) ? 1 : 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_w", done_w, 1);
        chk("done_s", done_s, 1);
        chk("busy_after", busy_w, 0);
        chk("out_valid_after", out_valid_s, 0);
        @(negedge clk);
        chk("done_w_drop", done_w, 0);
        chk("done_s_drop", done_s, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit lw, input bit lb, input int gap, input int stall_at, input bit poke);
        if (lw) for (int k = 0; k < NP; k++) mw[k] = wq[k];
        if (lb) for (int k = 0; k < NP; k++) mb[k] = bq[k];
        model_run();
        start  = 1'b1;
        load_w = lw;
        load_b = lb;
        len    = 8'(xq.size());
        @(posedge clk);
        #1;
        start  = 1'b0;
        load_w = 1'b0;
        load_b = 1'b0;
        len    = '0;
        chk("busy_run", busy_w, 1);
        if (lw) for (int k = 0; k < NP; k++) send(wq[k], gap);
        if (lb) for (int k = 0; k < NP; k++) send(bq[k], gap);
        for (int k = 0; k < xq.size(); k++) begin
            if (poke && k == 1) begin
                start  = 1'b1;
                load_b = 1'b1;
                @(posedge clk);
                #1;
                start  = 1'b0;
                load_b = 1'b0;
            end
            send(xq[k], gap);
        end
        drain(stall_at);
    endtask

    task automatic set_test1();
        wq = '{1, 2, 3, 4};
        bq = '{0, 0, 0, 0};
        xq = '{1, 1, 1};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NP; k++) begin
            mw[k] = 0;
            mb[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_w, 0);
        chk("rst_out_valid", out_valid_w, 0);
        chk("rst_in_ready", in_ready_s, 0);
        chk("rst_out_data", out_data_w, 0);
        chk("rst_done", done_s, 0);
        chk("rst_out_last", out_last_w, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic run
        set_test1();
        chk("t1_ref_pe0", 0, 0 + 3 - 3);
        run(1'b1, 1'b1, 0, NP, 1'b0);

        // 2: bias-only reload, weights retained, no stream
        bq = '{5, 5, 5, 5};
        xq = {};
        run(1'b0, 1'b1, 0, NP, 1'b0);

        // 3: overflow wrap vs saturate
        wq = '{-8, 0, 0, 0};
        bq = '{0, 0, 0, 0};
        xq = '{-8, -8, -8};
        run(1'b1, 1'b1, 0, NP, 1'b0);
        chk("t3_wrap_pe0", out_data_w, 0);
        chk("t3_model_wrap", exp_w[0], -64);
        chk("t3_model_sat", exp_s[0], 127);

        // 4: backpressure on both sides
        set_test1();
        run(1'b1, 1'b1, 2, 2, 1'b0);

        // 5: reset mid-stream, then zeros, then ignored start while busy
        set_test1();
        start = 1'b1; load_w = 1'b1; load_b = 1'b1; len = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0; load_w = 1'b0; load_b = 1'b0; len = '0;
        for (int k = 0; k < NP; k++) send(wq[k], 0);
        for (int k = 0; k < NP; k++) send(bq[k], 0);
        send(1, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_w", busy_w, 0);
        chk("mid_rst_busy_s", busy_s, 0);
        chk("mid_rst_out_valid", out_valid_w, 0);
        chk("mid_rst_in_ready", in_ready_w, 0);
        for (int k = 0; k < NP; k++) begin
            mw[k] = 0;
            mb[k] = 0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xq = {};
        run(1'b0, 1'b0, 0, NP, 1'b0);
        set_test1();
        run(1'b1, 1'b1, 1, 1, 1'b1);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            bit lw;
            bit lb;
            int n;
            lw = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            lb = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wq = {};
            bq = {};
            xq = {};
            for (int k = 0; k < NP; k++) begin
                wq.push_back(int'($urandom_range(0, 15)) - 8);
                bq.push_back(int'($urandom_range(0, 15)) - 8);
            end
            n = int'($urandom_range(0, 7));
            for (int k = 0; k < n; k++) xq.push_back(int'($urandom_range(0, 15)) - 8);
            run(lw, lb, int'($urandom_range(0, 2)), int'($urandom_range(0, NP)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
